// File: rtl/acc_drain.sv
// Drains signed partial sums from the show-ahead ACC FIFO, adds GroupSize of them
// into one wider result and hands it downstream on a valid/ready handshake.
module acc_drain #(
  parameter int DataWidth  = 32,
  parameter int OutWidth   = 40,
  parameter int GroupSize  = 4,
  parameter int CountWidth = 2
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 FifoEmpty,
  input  logic [DataWidth-1:0] FifoData,
  output logic                 FifoPop,
  input  logic                 OutReady,
  output logic                 OutValid,
  output logic [OutWidth-1:0]  OutData,
  output logic                 Busy
);

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  localparam logic [CountWidth-1:0] COUNT_ZERO = {CountWidth{1'b0}};
  localparam logic [CountWidth-1:0] COUNT_ONE  = CountWidth'(1'b1);
  localparam logic [CountWidth-1:0] COUNT_LAST = CountWidth'(GroupSize - 1);

  logic [0:0]            state_r;
  logic [CountWidth-1:0] count_r;
  logic [OutWidth-1:0]   acc_r;
  logic [OutWidth-1:0]   out_data_r;
  logic                  out_valid_r;
  logic                  busy_r;

  logic [0:0]            state_next_s;
  logic [CountWidth-1:0] count_next_s;
  logic [OutWidth-1:0]   acc_next_s;
  logic [OutWidth-1:0]   out_data_next_s;
  logic                  out_valid_next_s;
  logic                  busy_next_s;
  logic                  pop_s;
  logic [OutWidth-1:0]   entry_ext_s;
  logic [OutWidth-1:0]   sum_s;

  // Pop decode and the running sum; the first entry of a group restarts from zero.
  always_comb begin
    pop_s       = (state_r == ST_ACCUM) & ~FifoEmpty & ~aclr;
    entry_ext_s = OutWidth'($signed(FifoData));
    sum_s       = ((count_r == COUNT_ZERO) ? {OutWidth{1'b0}} : acc_r) + entry_ext_s;
  end

  assign FifoPop  = pop_s;
  assign OutValid = out_valid_r;
  assign OutData  = out_data_r;
  assign Busy     = busy_r;

  // Next-state logic: accumulate on pops, close the group on the last entry, wait for the handshake.
  always_comb begin
    state_next_s     = state_r;
    count_next_s     = count_r;
    acc_next_s       = acc_r;
    out_data_next_s  = out_data_r;
    out_valid_next_s = out_valid_r;
    case (state_r)
      ST_ACCUM: begin
        if (pop_s) begin
          acc_next_s = sum_s;
          if (count_r == COUNT_LAST) begin
            out_data_next_s  = sum_s;
            out_valid_next_s = 1'b1;
            count_next_s     = COUNT_ZERO;
            state_next_s     = ST_HOLD;
          end else begin
            count_next_s = count_r + COUNT_ONE;
          end
        end else begin
          acc_next_s = acc_r;
        end
      end
      ST_HOLD: begin
        // No pop in the handshake cycle; gathering restarts on the following edge.
        if (OutReady) begin
          out_valid_next_s = 1'b0;
          state_next_s     = ST_ACCUM;
        end else begin
          out_valid_next_s = 1'b1;
        end
      end
      default: begin
        state_next_s     = ST_ACCUM;
        count_next_s     = COUNT_ZERO;
        out_valid_next_s = 1'b0;
      end
    endcase
    busy_next_s = (count_next_s != COUNT_ZERO) | out_valid_next_s;
  end

  // State and output registers; reset discards any partial group or pending result.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_r     <= ST_ACCUM;
      count_r     <= COUNT_ZERO;
      acc_r       <= {OutWidth{1'b0}};
      out_data_r  <= {OutWidth{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      count_r     <= count_next_s;
      acc_r       <= acc_next_s;
      out_data_r  <= out_data_next_s;
      out_valid_r <= out_valid_next_s;
      busy_r      <= busy_next_s;
    end
  end

endmodule

// File: tb/tb_acc_drain.sv
// Self-checking bench for acc_drain: directed scenarios against fixed expected
// values plus a randomized run against a cycle model and a push-side group scoreboard.
module tb_acc_drain;

  localparam int GROUP = 4;

  logic        clk;
  logic        aclr;
  logic        FifoEmpty;
  logic [31:0] FifoData;
  logic        FifoPop;
  logic        OutReady;
  logic        OutValid;
  logic [39:0] OutData;
  logic        Busy;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] fifo_q[$];

  // cycle model state
  logic        m_hold = 1'b0;
  int          m_n    = 0;
  logic [39:0] m_sum  = 40'd0;
  logic [39:0] m_out  = 40'd0;
  logic        exp_pop, exp_valid, exp_busy;
  logic [39:0] exp_data;
  logic        obs_pop, obs_valid, obs_busy;
  logic [39:0] obs_data;

  logic        rec_pop[64];
  logic        rec_valid[64];
  logic        rec_busy[64];
  logic [39:0] rec_data[64];

  acc_drain #(.DataWidth(32), .OutWidth(40), .GroupSize(GROUP), .CountWidth(2)) dut (
    .clk(clk), .aclr(aclr), .FifoEmpty(FifoEmpty), .FifoData(FifoData),
    .FifoPop(FifoPop), .OutReady(OutReady), .OutValid(OutValid),
    .OutData(OutData), .Busy(Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [39:0] sext(input logic [31:0] v);
    return {{8{v[31]}}, v};
  endfunction

  task automatic push(input logic [31:0] v);
    fifo_q.push_back(v);
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step();
    FifoEmpty = (fifo_q.size() == 0);
    FifoData  = FifoEmpty ? $urandom : fifo_q[0];
    #1;
    if (aclr) begin
      m_hold = 1'b0; m_n = 0; m_sum = 40'd0;
    end
    exp_pop   = !m_hold && !FifoEmpty && !aclr;
    exp_valid = m_hold;
    exp_busy  = (m_n != 0) || m_hold;
    exp_data  = m_out;
    obs_pop   = FifoPop;
    obs_valid = OutValid;
    obs_busy  = Busy;
    obs_data  = OutData;
    if (!aclr) begin
      if (m_hold) begin
        if (OutReady) m_hold = 1'b0;
      end else if (exp_pop) begin
        m_sum = m_sum + sext(FifoData);
        m_n++;
        if (m_n == GROUP) begin
          m_out = m_sum; m_hold = 1'b1; m_n = 0; m_sum = 40'd0;
        end
      end
    end
    @(posedge clk);
    if (obs_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      rec_pop[i] = obs_pop; rec_valid[i] = obs_valid;
      rec_busy[i] = obs_busy; rec_data[i] = obs_data;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    FifoEmpty = 1'b0; FifoData = 32'd5;
    #1;
    n_vec++;
    if ({FifoPop, OutValid, Busy} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: pop/valid/busy=%b required 000", {FifoPop, OutValid, Busy});
    end
    n_vec++;
    if (OutData !== 40'd0) begin
      n_err++; $display("FAIL reset_data: got %h required 0", OutData);
    end
    FifoEmpty = 1'b1;
    @(negedge clk);
    aclr = 1'b0;
  endtask

  task automatic test_basic();
    logic [5:0] p, v;
    OutReady = 1'b1;
    push(32'd1); push(32'd2); push(32'd3); push(32'd4);
    run(6);
    for (int i = 0; i < 6; i++) begin p[i] = rec_pop[i]; v[i] = rec_valid[i]; end
    n_vec++;
    if (p !== 6'b001111) begin n_err++; $display("FAIL basic_pop: got %b required 001111", p); end
    n_vec++;
    if (v !== 6'b010000) begin n_err++; $display("FAIL basic_valid: got %b required 010000", v); end
    n_vec++;
    if (rec_data[4] !== 40'd10) begin n_err++; $display("FAIL basic_data: got %0d required 10", rec_data[4]); end
  endtask

  task automatic test_signed_wrap();
    OutReady = 1'b1;
    for (int i = 0; i < 4; i++) push(32'hFFFF_FFFF);
    run(5);
    n_vec++;
    if (!rec_valid[4] || rec_data[4] !== 40'hFF_FFFF_FFFC) begin
      n_err++; $display("FAIL neg_sum: valid=%b data=%h required 1/fffffffffc", rec_valid[4], rec_data[4]);
    end
    for (int i = 0; i < 4; i++) push(32'h7FFF_FFFF);
    run(5);
    n_vec++;
    if (!rec_valid[4] || rec_data[4] !== 40'h01_FFFF_FFFC) begin
      n_err++; $display("FAIL max_sum: valid=%b data=%h required 1/01fffffffc", rec_valid[4], rec_data[4]);
    end
  endtask

  task automatic test_backpressure();
    logic stable;
    OutReady = 1'b0;
    push(32'd1); push(32'd1); push(32'd1); push(32'd1);
    push(32'd9); push(32'd0); push(32'd0); push(32'd0);
    run(9);
    stable = 1'b1;
    for (int i = 4; i < 9; i++)
      if (!rec_valid[i] || rec_pop[i] || rec_data[i] !== 40'd4) stable = 1'b0;
    n_vec++;
    if (!stable) begin n_err++; $display("FAIL bp_hold: valid/pop/data not held at 1/0/4 for 5 cycles"); end
    OutReady = 1'b1;
    run(6);
    n_vec++;
    if ({rec_valid[0], rec_pop[0], rec_valid[1], rec_pop[1]} !== 4'b1001) begin
      n_err++; $display("FAIL bp_release: valid,pop,valid,pop=%b required 1001",
                        {rec_valid[0], rec_pop[0], rec_valid[1], rec_pop[1]});
    end
    n_vec++;
    if (!rec_valid[5] || rec_data[5] !== 40'd9) begin
      n_err++; $display("FAIL bp_next: valid=%b data=%0d required 1/9", rec_valid[5], rec_data[5]);
    end
  endtask

  task automatic test_starvation();
    logic ok;
    OutReady = 1'b1;
    push(32'd5); push(32'd6);
    run(2);
    run(10);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) if (rec_pop[i] || !rec_busy[i] || rec_valid[i]) ok = 1'b0;
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL starve_gap: pop/busy/valid not 0/1/0 throughout gap"); end
    push(32'd7); push(32'd8);
    run(3);
    n_vec++;
    if (!rec_valid[2] || rec_data[2] !== 40'd26) begin
      n_err++; $display("FAIL starve_sum: valid=%b data=%0d required 1/26", rec_valid[2], rec_data[2]);
    end
  endtask

  task automatic test_reset_mid();
    OutReady = 1'b1;
    push(32'd3); push(32'd3);
    run(2);
    aclr = 1'b1;
    #1;
    n_vec++;
    if ({FifoPop, OutValid, Busy} !== 3'b000) begin
      n_err++; $display("FAIL rst_mid: pop/valid/busy=%b required 000", {FifoPop, OutValid, Busy});
    end
    run(1);
    aclr = 1'b0;
    for (int i = 0; i < 4; i++) push(32'd1);
    run(5);
    n_vec++;
    if (!rec_valid[4] || rec_data[4] !== 40'd4) begin
      n_err++; $display("FAIL rst_mid_sum: valid=%b data=%0d required 1/4", rec_valid[4], rec_data[4]);
    end
    OutReady = 1'b0;
    for (int i = 0; i < 4; i++) push(32'd2);
    run(6);
    aclr = 1'b1;
    #1;
    n_vec++;
    if ({OutValid, Busy} !== 2'b00) begin
      n_err++; $display("FAIL rst_hold: valid/busy=%b required 00", {OutValid, Busy});
    end
    run(1);
    aclr = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [9:0] v;
    OutReady = 1'b1;
    for (int i = 0; i < 8; i++) push(32'd2);
    run(10);
    for (int i = 0; i < 10; i++) v[i] = rec_valid[i];
    n_vec++;
    if (v !== 10'b10_0001_0000) begin n_err++; $display("FAIL b2b_valid: got %b required 1000010000", v); end
    n_vec++;
    if (rec_data[4] !== 40'd8 || rec_data[9] !== 40'd8) begin
      n_err++; $display("FAIL b2b_data: got %0d,%0d required 8,8", rec_data[4], rec_data[9]);
    end
  endtask

  task automatic test_random();
    logic [39:0] sb_q[$];
    logic [39:0] sb_acc;
    int          sb_n;
    logic [31:0] v;
    logic [39:0] want;
    sb_acc = 40'd0; sb_n = 0;
    fifo_q.delete();
    aclr = 1'b1;
    run(1);
    aclr = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 3))
          0: v = 32'h7FFF_FFFF;
          1: v = 32'h8000_0000;
          default: v = $urandom;
        endcase
        push(v);
        sb_acc = sb_acc + sext(v);
        sb_n++;
        if (sb_n == GROUP) begin sb_q.push_back(sb_acc); sb_acc = 40'd0; sb_n = 0; end
      end
      OutReady = ($urandom_range(0, 2) != 0);
      step();
      n_vec++;
      if ({obs_pop, obs_valid, obs_busy} !== {exp_pop, exp_valid, exp_busy} ||
          (exp_valid && obs_data !== exp_data)) begin
        n_err++;
        $display("FAIL rand_cycle %0d: pop/valid/busy=%b data=%h required %b / %h", c,
                 {obs_pop, obs_valid, obs_busy}, obs_data, {exp_pop, exp_valid, exp_busy}, exp_data);
      end
      if (obs_valid && OutReady) begin
        want = (sb_q.size() > 0) ? sb_q.pop_front() : 40'hXX_XXXX_XXXX;
        n_vec++;
        if (obs_data !== want) begin
          n_err++; $display("FAIL rand_result: got %h required %h", obs_data, want);
        end
      end
    end
  endtask

  initial begin
    aclr = 1'b1; OutReady = 1'b0; FifoEmpty = 1'b1; FifoData = 32'd0;
    test_reset();
    test_basic();
    test_signed_wrap();
    test_backpressure();
    test_starvation();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
